// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / query / retire bundle of the reorder buffer.
// The slave side is the reorder buffer itself; the master side is whoever
// drives dispatch and the CDB and consumes renames, operands and retirement.
interface reorder_buffer_if;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_is_branch;
  logic        issue_pred_taken;
  logic [31:0] issue_alt_pc;
  logic        full;
  logic        update_valid;
  logic [3:0]  update_ROB_pos;
  logic [4:0]  update_rd;
  logic        cdb_valid;
  logic [3:0]  cdb_pos;
  logic [31:0] cdb_val;
  logic        cdb_taken;
  logic [3:0]  q1_pos;
  logic [3:0]  q2_pos;
  logic        q1_ready;
  logic        q2_ready;
  logic [31:0] q1_val;
  logic [31:0] q2_val;
  logic        commit_valid;
  logic [3:0]  commit_ROB_pos;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic        jump_wrong;
  logic [31:0] jump_pc;

  modport master (
    output issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    output cdb_valid, cdb_pos, cdb_val, cdb_taken, q1_pos, q2_pos,
    input  full, update_valid, update_ROB_pos, update_rd,
    input  q1_ready, q2_ready, q1_val, q2_val,
    input  commit_valid, commit_ROB_pos, commit_rd, commit_val, jump_wrong, jump_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
    input  cdb_valid, cdb_pos, cdb_val, cdb_taken, q1_pos, q2_pos,
    output full, update_valid, update_ROB_pos, update_rd,
    output q1_ready, q2_ready, q1_val, q2_val,
    output commit_valid, commit_ROB_pos, commit_rd, commit_val, jump_wrong, jump_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates rename tags at dispatch,
// captures CDB results, retires strictly in program order and raises a
// one-cycle flush pulse when a retiring branch turns out mispredicted.
module reorder_buffer (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  reorder_buffer_if.slave rob
);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [3:0]  head_r;
  logic [3:0]  tail_r;
  logic [4:0]  count_r;
  logic [0:0]  state_r;
  logic [15:0] busy_r;
  logic [15:0] ready_r;
  logic [15:0] is_branch_r;
  logic [15:0] pred_taken_r;
  logic [15:0] taken_r;
  logic [4:0]  rd_r     [16];
  logic [31:0] val_r    [16];
  logic [31:0] alt_pc_r [16];
  logic [31:0] flush_pc_r;

  logic        commit_valid_r;
  logic [3:0]  commit_pos_r;
  logic [4:0]  commit_rd_r;
  logic [31:0] commit_val_r;
  logic        jump_wrong_r;
  logic [31:0] jump_pc_r;

  logic        full_s;
  logic        accept_s;
  logic        cdb_wr_s;
  logic        commit_s;
  logic        mispredict_s;

  // Handshake decode; full uses the current count so a same-cycle commit never frees a slot.
  always_comb begin
    full_s       = (count_r == 5'd16) | (state_r == ST_FLUSH) | jump_wrong_r;
    accept_s     = rob.issue_valid & ~full_s & rdy;
    cdb_wr_s     = rob.cdb_valid & rdy & (state_r == ST_RUN) & busy_r[rob.cdb_pos];
    commit_s     = rdy & (state_r == ST_RUN) & (count_r != 5'd0) & ready_r[head_r];
    mispredict_s = commit_s & is_branch_r[head_r] & (taken_r[head_r] != pred_taken_r[head_r]);
  end

  // Operand queries with zero-latency bypass from the CDB.
  always_comb begin
    if (rob.cdb_valid && (rob.cdb_pos == rob.q1_pos)) begin
      rob.q1_ready = 1'b1;
      rob.q1_val   = rob.cdb_val;
    end else begin
      rob.q1_ready = ready_r[rob.q1_pos];
      rob.q1_val   = val_r[rob.q1_pos];
    end
    if (rob.cdb_valid && (rob.cdb_pos == rob.q2_pos)) begin
      rob.q2_ready = 1'b1;
      rob.q2_val   = rob.cdb_val;
    end else begin
      rob.q2_ready = ready_r[rob.q2_pos];
      rob.q2_val   = val_r[rob.q2_pos];
    end
  end

  assign rob.full           = full_s;
  assign rob.update_valid   = accept_s;
  assign rob.update_ROB_pos = tail_r;
  assign rob.update_rd      = rob.issue_rd;
  assign rob.commit_valid   = commit_valid_r;
  assign rob.commit_ROB_pos = commit_pos_r;
  assign rob.commit_rd      = commit_rd_r;
  assign rob.commit_val     = commit_val_r;
  assign rob.jump_wrong     = jump_wrong_r;
  assign rob.jump_pc        = jump_pc_r;

  // Pointers, occupancy, RUN/FLUSH sequencing and the registered retire/flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r         <= 4'd0;
      tail_r         <= 4'd0;
      count_r        <= 5'd0;
      state_r        <= ST_RUN;
      flush_pc_r     <= 32'd0;
      commit_valid_r <= 1'b0;
      commit_pos_r   <= 4'd0;
      commit_rd_r    <= 5'd0;
      commit_val_r   <= 32'd0;
      jump_wrong_r   <= 1'b0;
      jump_pc_r      <= 32'd0;
    end else if (!rdy) begin
      commit_valid_r <= 1'b0;
      jump_wrong_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          jump_wrong_r   <= 1'b0;
          commit_valid_r <= commit_s;
          if (commit_s) begin
            commit_pos_r <= head_r;
            commit_rd_r  <= rd_r[head_r];
            commit_val_r <= val_r[head_r];
            head_r       <= head_r + 4'd1;
          end
          if (accept_s) begin
            tail_r <= tail_r + 4'd1;
          end
          if (accept_s && !commit_s) begin
            count_r <= count_r + 5'd1;
          end else if (!accept_s && commit_s) begin
            count_r <= count_r - 5'd1;
          end
          // Wrong-path entries are discarded wholesale in the FLUSH cycle.
          if (mispredict_s) begin
            flush_pc_r <= alt_pc_r[head_r];
            state_r    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          commit_valid_r <= 1'b0;
          jump_wrong_r   <= 1'b1;
          jump_pc_r      <= flush_pc_r;
          head_r         <= 4'd0;
          tail_r         <= 4'd0;
          count_r        <= 5'd0;
          state_r        <= ST_RUN;
        end
        default: begin
          commit_valid_r <= 1'b0;
          jump_wrong_r   <= 1'b0;
          state_r        <= ST_RUN;
        end
      endcase
    end
  end

  // Per-entry busy/ready flags: set on allocate/result, cleared on retire and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r  <= 16'd0;
      ready_r <= 16'd0;
    end else if (rdy) begin
      if (state_r == ST_FLUSH) begin
        busy_r  <= 16'd0;
        ready_r <= 16'd0;
      end else begin
        if (accept_s) begin
          busy_r[tail_r]  <= 1'b1;
          ready_r[tail_r] <= 1'b0;
        end
        if (cdb_wr_s) begin
          ready_r[rob.cdb_pos] <= 1'b1;
        end
        if (commit_s) begin
          busy_r[head_r]  <= 1'b0;
          ready_r[head_r] <= 1'b0;
        end
      end
    end
  end

  // Entry payload; only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (accept_s) begin
        rd_r[tail_r]         <= rob.issue_rd;
        is_branch_r[tail_r]  <= rob.issue_is_branch;
        pred_taken_r[tail_r] <= rob.issue_pred_taken;
        alt_pc_r[tail_r]     <= rob.issue_alt_pc;
      end
      if (cdb_wr_s) begin
        val_r[rob.cdb_pos]   <= rob.cdb_val;
        taken_r[rob.cdb_pos] <= rob.cdb_taken;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered) or 1ns later (combinational).
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   failures = 0;

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .rob (rob_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rob_bus.issue_valid      = 1'b0;
    rob_bus.issue_rd         = 5'd0;
    rob_bus.issue_is_branch  = 1'b0;
    rob_bus.issue_pred_taken = 1'b0;
    rob_bus.issue_alt_pc     = 32'd0;
    rob_bus.cdb_valid        = 1'b0;
    rob_bus.cdb_pos          = 4'd0;
    rob_bus.cdb_val          = 32'd0;
    rob_bus.cdb_taken        = 1'b0;
    rob_bus.q1_pos           = 4'd0;
    rob_bus.q2_pos           = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (rob_bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", rob_bus.full); end
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit_valid got=%0b exp=0", rob_bus.commit_valid); end
    checks++; if (rob_bus.jump_wrong !== 1'b0) begin failures++; $display("FAIL reset_jump_wrong got=%0b exp=0", rob_bus.jump_wrong); end
    checks++; if (rob_bus.update_ROB_pos !== 4'd0) begin failures++; $display("FAIL reset_tail got=%0d exp=0", rob_bus.update_ROB_pos); end
    checks++; if (rob_bus.q1_ready !== 1'b0) begin failures++; $display("FAIL reset_q1_ready got=%0b exp=0", rob_bus.q1_ready); end
  endtask

  task automatic test_issue_bypass();
    rob_bus.issue_valid = 1'b1;
    rob_bus.issue_rd    = 5'd5;
    #1;
    checks++; if (rob_bus.update_valid !== 1'b1) begin failures++; $display("FAIL issue_update_valid got=%0b exp=1", rob_bus.update_valid); end
    checks++; if (rob_bus.update_ROB_pos !== 4'd0) begin failures++; $display("FAIL issue_tag got=%0d exp=0", rob_bus.update_ROB_pos); end
    checks++; if (rob_bus.update_rd !== 5'd5) begin failures++; $display("FAIL issue_update_rd got=%0d exp=5", rob_bus.update_rd); end
    step();
    rob_bus.issue_valid = 1'b0;
    rob_bus.q1_pos = 4'd0;
    rob_bus.q2_pos = 4'd0;
    #1;
    checks++; if (rob_bus.q1_ready !== 1'b0) begin failures++; $display("FAIL query_not_ready got=%0b exp=0", rob_bus.q1_ready); end
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL no_commit_unresolved got=%0b exp=0", rob_bus.commit_valid); end
    rob_bus.cdb_valid = 1'b1;
    rob_bus.cdb_pos   = 4'd0;
    rob_bus.cdb_val   = 32'h0000_1234;
    #1;
    checks++; if (rob_bus.q1_ready !== 1'b1) begin failures++; $display("FAIL bypass_q1_ready got=%0b exp=1", rob_bus.q1_ready); end
    checks++; if (rob_bus.q1_val !== 32'h0000_1234) begin failures++; $display("FAIL bypass_q1_val got=%h exp=00001234", rob_bus.q1_val); end
    checks++; if (rob_bus.q2_val !== 32'h0000_1234) begin failures++; $display("FAIL bypass_q2_val got=%h exp=00001234", rob_bus.q2_val); end
    step();
    rob_bus.cdb_valid = 1'b0;
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL cdb_commit_latency got=%0b exp=0", rob_bus.commit_valid); end
    step();
    checks++; if (rob_bus.commit_valid !== 1'b1) begin failures++; $display("FAIL commit0_valid got=%0b exp=1", rob_bus.commit_valid); end
    checks++; if (rob_bus.commit_ROB_pos !== 4'd0) begin failures++; $display("FAIL commit0_pos got=%0d exp=0", rob_bus.commit_ROB_pos); end
    checks++; if (rob_bus.commit_rd !== 5'd5) begin failures++; $display("FAIL commit0_rd got=%0d exp=5", rob_bus.commit_rd); end
    checks++; if (rob_bus.commit_val !== 32'h0000_1234) begin failures++; $display("FAIL commit0_val got=%h exp=00001234", rob_bus.commit_val); end
    step();
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL commit0_single got=%0b exp=0", rob_bus.commit_valid); end
  endtask

  task automatic test_full_in_order();
    logic [3:0] exp_tag;
    logic [3:0] order [4];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_tag = 4'(i);
      rob_bus.issue_valid = 1'b1;
      rob_bus.issue_rd    = 5'(i + 1);
      #1;
      checks++; if (rob_bus.update_ROB_pos !== exp_tag) begin failures++; $display("FAIL fill_tag got=%0d exp=%0d", rob_bus.update_ROB_pos, exp_tag); end
      step();
    end
    #1;
    checks++; if (rob_bus.full !== 1'b1) begin failures++; $display("FAIL full_at_16 got=%0b exp=1", rob_bus.full); end
    checks++; if (rob_bus.update_valid !== 1'b0) begin failures++; $display("FAIL issue17_rejected got=%0b exp=0", rob_bus.update_valid); end
    step();
    rob_bus.issue_valid = 1'b0;
    order[0] = 4'd3; order[1] = 4'd0; order[2] = 4'd1; order[3] = 4'd2;
    // Tags 3 and 0 resolve first; retire of 0 appears after the edge that writes tag 1.
    for (int i = 0; i < 4; i++) begin
      rob_bus.cdb_valid = 1'b1;
      rob_bus.cdb_pos   = order[i];
      rob_bus.cdb_val   = 32'h0000_00a0 + 32'(order[i]);
      rob_bus.cdb_taken = 1'b0;
      step();
      if (i < 2) begin
        checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_no_commit got=%0b exp=0 step=%0d", rob_bus.commit_valid, i); end
      end else begin
        checks++; if (rob_bus.commit_valid !== 1'b1) begin failures++; $display("FAIL ooo_commit_valid got=%0b exp=1 step=%0d", rob_bus.commit_valid, i); end
        checks++; if (rob_bus.commit_ROB_pos !== 4'(i - 2)) begin failures++; $display("FAIL ooo_commit_pos got=%0d exp=%0d", rob_bus.commit_ROB_pos, i - 2); end
      end
    end
    rob_bus.cdb_valid = 1'b0;
    #1;
    checks++; if (rob_bus.full !== 1'b0) begin failures++; $display("FAIL full_after_commit got=%0b exp=0", rob_bus.full); end
    step();
    checks++; if (rob_bus.commit_ROB_pos !== 4'd2) begin failures++; $display("FAIL ooo_commit_pos got=%0d exp=2", rob_bus.commit_ROB_pos); end
    step();
    checks++; if (rob_bus.commit_ROB_pos !== 4'd3) begin failures++; $display("FAIL ooo_commit_pos got=%0d exp=3", rob_bus.commit_ROB_pos); end
    checks++; if (rob_bus.commit_rd !== 5'd4) begin failures++; $display("FAIL ooo_commit3_rd got=%0d exp=4", rob_bus.commit_rd); end
    checks++; if (rob_bus.commit_val !== 32'h0000_00a3) begin failures++; $display("FAIL ooo_commit3_val got=%h exp=000000a3", rob_bus.commit_val); end
    step();
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_stall_at_4 got=%0b exp=0", rob_bus.commit_valid); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    // Issue tag n, resolve tag n-1 on the CDB, retire tag n-2, every cycle.
    for (int n = 0; n < 22; n++) begin
      rob_bus.issue_valid = (n < 20);
      rob_bus.issue_rd    = 5'((n % 31) + 1);
      rob_bus.cdb_valid   = (n >= 1) && (n <= 20);
      rob_bus.cdb_pos     = 4'((n + 15) % 16);
      rob_bus.cdb_val     = 32'h0000_5000 + 32'(n - 1);
      #1;
      if (n < 20) begin
        checks++; if (rob_bus.update_ROB_pos !== 4'(n % 16)) begin failures++; $display("FAIL wrap_tag got=%0d exp=%0d", rob_bus.update_ROB_pos, n % 16); end
      end
      checks++; if (rob_bus.full !== 1'b0) begin failures++; $display("FAIL wrap_full got=%0b exp=0 n=%0d", rob_bus.full, n); end
      step();
      if (n >= 2) begin
        checks++; if (rob_bus.commit_valid !== 1'b1) begin failures++; $display("FAIL wrap_commit_valid got=%0b exp=1 n=%0d", rob_bus.commit_valid, n); end
        checks++; if (rob_bus.commit_ROB_pos !== 4'((n - 2) % 16)) begin failures++; $display("FAIL wrap_commit_pos got=%0d exp=%0d", rob_bus.commit_ROB_pos, (n - 2) % 16); end
        checks++; if (rob_bus.commit_val !== 32'h0000_5000 + 32'(n - 2)) begin failures++; $display("FAIL wrap_commit_val got=%h exp=%h", rob_bus.commit_val, 32'h0000_5000 + 32'(n - 2)); end
      end else begin
        checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL wrap_early_commit got=%0b exp=0", rob_bus.commit_valid); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_mispredict();
    // Buffer is empty with head = tail = 4 after the wrap test.
    rob_bus.issue_valid      = 1'b1;
    rob_bus.issue_rd         = 5'd0;
    rob_bus.issue_is_branch  = 1'b1;
    rob_bus.issue_pred_taken = 1'b0;
    rob_bus.issue_alt_pc     = 32'h0000_0100;
    #1;
    checks++; if (rob_bus.update_ROB_pos !== 4'd4) begin failures++; $display("FAIL br_tag got=%0d exp=4", rob_bus.update_ROB_pos); end
    step();
    rob_bus.issue_is_branch = 1'b0;
    rob_bus.issue_alt_pc    = 32'h0000_0dea;
    for (int i = 0; i < 3; i++) begin
      rob_bus.issue_rd = 5'(10 + i);
      step();
    end
    rob_bus.issue_valid = 1'b0;
    rob_bus.cdb_valid   = 1'b1;
    rob_bus.cdb_pos     = 4'd4;
    rob_bus.cdb_val     = 32'd0;
    rob_bus.cdb_taken   = 1'b1;
    step();
    rob_bus.cdb_valid = 1'b0;
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL br_early_commit got=%0b exp=0", rob_bus.commit_valid); end
    step();
    checks++; if (rob_bus.commit_valid !== 1'b1) begin failures++; $display("FAIL br_commit_valid got=%0b exp=1", rob_bus.commit_valid); end
    checks++; if (rob_bus.commit_ROB_pos !== 4'd4) begin failures++; $display("FAIL br_commit_pos got=%0d exp=4", rob_bus.commit_ROB_pos); end
    checks++; if (rob_bus.jump_wrong !== 1'b0) begin failures++; $display("FAIL br_jump_early got=%0b exp=0", rob_bus.jump_wrong); end
    // In FLUSH: both a younger CDB write and a new issue must be ignored.
    rob_bus.cdb_valid   = 1'b1;
    rob_bus.cdb_pos     = 4'd5;
    rob_bus.cdb_val     = 32'h0000_0055;
    rob_bus.issue_valid = 1'b1;
    rob_bus.issue_rd    = 5'd3;
    #1;
    checks++; if (rob_bus.full !== 1'b1) begin failures++; $display("FAIL flush_full got=%0b exp=1", rob_bus.full); end
    checks++; if (rob_bus.update_valid !== 1'b0) begin failures++; $display("FAIL flush_issue_blocked got=%0b exp=0", rob_bus.update_valid); end
    step();
    rob_bus.cdb_valid = 1'b0;
    rob_bus.q1_pos    = 4'd5;
    #1;
    checks++; if (rob_bus.jump_wrong !== 1'b1) begin failures++; $display("FAIL jump_wrong_pulse got=%0b exp=1", rob_bus.jump_wrong); end
    checks++; if (rob_bus.jump_pc !== 32'h0000_0100) begin failures++; $display("FAIL jump_pc got=%h exp=00000100", rob_bus.jump_pc); end
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL flush_no_commit got=%0b exp=0", rob_bus.commit_valid); end
    checks++; if (rob_bus.update_valid !== 1'b0) begin failures++; $display("FAIL jump_cycle_issue_blocked got=%0b exp=0", rob_bus.update_valid); end
    checks++; if (rob_bus.q1_ready !== 1'b0) begin failures++; $display("FAIL flush_cdb_ignored got=%0b exp=0", rob_bus.q1_ready); end
    step();
    #1;
    checks++; if (rob_bus.jump_wrong !== 1'b0) begin failures++; $display("FAIL jump_wrong_one_cycle got=%0b exp=0", rob_bus.jump_wrong); end
    checks++; if (rob_bus.full !== 1'b0) begin failures++; $display("FAIL post_flush_full got=%0b exp=0", rob_bus.full); end
    checks++; if (rob_bus.update_valid !== 1'b1) begin failures++; $display("FAIL post_flush_accept got=%0b exp=1", rob_bus.update_valid); end
    checks++; if (rob_bus.update_ROB_pos !== 4'd0) begin failures++; $display("FAIL post_flush_tag got=%0d exp=0", rob_bus.update_ROB_pos); end
    step();
    rob_bus.issue_valid = 1'b0;
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL post_flush_no_commit got=%0b exp=0", rob_bus.commit_valid); end
  endtask

  task automatic test_rdy_freeze_then_reset();
    // Tag 0 (rd 3) pending; allocate tag 1 and resolve tag 0 together.
    rob_bus.issue_valid = 1'b1;
    rob_bus.issue_rd    = 5'd9;
    rob_bus.cdb_valid   = 1'b1;
    rob_bus.cdb_pos     = 4'd0;
    rob_bus.cdb_val     = 32'h0000_0777;
    step();
    rdy = 1'b0;
    rob_bus.cdb_pos = 4'd1;
    rob_bus.cdb_val = 32'h0000_0888;
    rob_bus.q1_pos  = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rob_bus.update_valid !== 1'b0) begin failures++; $display("FAIL freeze_no_accept got=%0b exp=0", rob_bus.update_valid); end
      step();
      checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL freeze_no_commit got=%0b exp=0 cyc=%0d", rob_bus.commit_valid, i); end
    end
    rob_bus.cdb_valid   = 1'b0;
    rob_bus.issue_valid = 1'b0;
    #1;
    checks++; if (rob_bus.q1_ready !== 1'b1) begin failures++; $display("FAIL freeze_ready_held got=%0b exp=1", rob_bus.q1_ready); end
    checks++; if (rob_bus.q1_val !== 32'h0000_0777) begin failures++; $display("FAIL freeze_val_held got=%h exp=00000777", rob_bus.q1_val); end
    rdy = 1'b1;
    step();
    checks++; if (rob_bus.commit_valid !== 1'b1) begin failures++; $display("FAIL thaw_commit_valid got=%0b exp=1", rob_bus.commit_valid); end
    checks++; if (rob_bus.commit_rd !== 5'd3) begin failures++; $display("FAIL thaw_commit_rd got=%0d exp=3", rob_bus.commit_rd); end
    checks++; if (rob_bus.commit_val !== 32'h0000_0777) begin failures++; $display("FAIL thaw_commit_val got=%h exp=00000777", rob_bus.commit_val); end
    rob_bus.q1_pos = 4'd1;
    #1;
    checks++; if (rob_bus.q1_ready !== 1'b0) begin failures++; $display("FAIL freeze_cdb_ignored got=%0b exp=0", rob_bus.q1_ready); end
    rob_bus.cdb_valid = 1'b1;
    step();
    rob_bus.cdb_valid = 1'b0;
    // Tag 1 would retire on this edge; reset must win.
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (rob_bus.commit_valid !== 1'b0) begin failures++; $display("FAIL rst_commit_valid got=%0b exp=0", rob_bus.commit_valid); end
    checks++; if (rob_bus.commit_ROB_pos !== 4'd0) begin failures++; $display("FAIL rst_commit_pos got=%0d exp=0", rob_bus.commit_ROB_pos); end
    checks++; if (rob_bus.commit_rd !== 5'd0) begin failures++; $display("FAIL rst_commit_rd got=%0d exp=0", rob_bus.commit_rd); end
    checks++; if (rob_bus.commit_val !== 32'd0) begin failures++; $display("FAIL rst_commit_val got=%h exp=0", rob_bus.commit_val); end
    checks++; if (rob_bus.jump_pc !== 32'd0) begin failures++; $display("FAIL rst_jump_pc got=%h exp=0", rob_bus.jump_pc); end
    checks++; if (rob_bus.jump_wrong !== 1'b0) begin failures++; $display("FAIL rst_jump_wrong got=%0b exp=0", rob_bus.jump_wrong); end
    checks++; if (rob_bus.full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", rob_bus.full); end
    checks++; if (rob_bus.q1_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_cleared got=%0b exp=0", rob_bus.q1_ready); end
    checks++; if (rob_bus.update_ROB_pos !== 4'd0) begin failures++; $display("FAIL rst_tail got=%0d exp=0", rob_bus.update_ROB_pos); end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_issue_bypass();
    test_full_in_order();
    test_back_to_back_wrap();
    test_mispredict();
    test_rdy_freeze_then_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the sequence");
    $fatal(1);
  end
endmodule
